// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode and FSM state types for the universal shift register
package shift_reg_pkg;

  // Manual operation select; encoding matches the 3-bit mode input.
  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    LOAD = 3'b011,
    ROR  = 3'b100,
    ROL  = 3'b101,
    ASR  = 3'b110,
    SHRN = 3'b111
  } mode_t;

  // Auto-serialise engine states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/usr_next_value.sv
// rtl/usr_next_value.sv - combinational next-value datapath for all eight manual modes
//
// Ports:
//   mode   : operation select
//   a      : current register contents
//   i_par  : parallel load data
//   msb_in : fill bit for shift right
//   lsb_in : fill bit for shift left
//   amt    : distance for the variable logical right shift
//   a_next : register value after the selected operation
module usr_next_value
  import shift_reg_pkg::*;
#(
  parameter int W  = 4,
  parameter int AW = $clog2(W)
) (
  input  mode_t          mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   i_par,
  input  logic           msb_in,
  input  logic           lsb_in,
  input  logic [AW-1:0]  amt,
  output logic [W-1:0]   a_next
);

  always_comb begin
    a_next = a;
    case (mode)
      HOLD: a_next = a;
      SHR:  a_next = {msb_in, a[W-1:1]};
      SHL:  a_next = {a[W-2:0], lsb_in};
      LOAD: a_next = i_par;
      ROR:  a_next = {a[0], a[W-1:1]};
      ROL:  a_next = {a[W-2:0], a[W-1]};
      ASR:  a_next = {a[W-1], a[W-1:1]};
      // A logical shift by amt >= W already yields zero, which covers the
      // out-of-range amounts reachable when W is not a power of two.
      SHRN: a_next = a >> amt;
      default: a_next = a;
    endcase
  end

endmodule

// File: rtl/universal_shift_register_n.sv
// rtl/universal_shift_register_n.sv - W-bit universal shift register with auto-serialise engine
//
// Ports:
//   CLK     : rising-edge clock
//   Clear_b : synchronous active-low reset, overrides en
//   en      : clock enable for register, FSM, counter and done
//   mode    : manual operation select, honoured only in IDLE without start
//   amt     : distance for mode SHRN
//   I_par   : parallel data for LOAD and for serialise
//   MSB_in  : fill bit at W-1 on right shifts and while serialising
//   LSB_in  : fill bit at 0 on left shifts
//   start   : request to serialise I_par LSB-first
//   A_par   : register contents
//   ser_out : A_par[0]
//   busy    : serialise FSM is in SHIFT
//   done    : one-cycle pulse after the last serial bit
module universal_shift_register_n
  import shift_reg_pkg::*;
#(
  parameter int W  = 4,
  parameter int AW = $clog2(W)
) (
  input  logic           CLK,
  input  logic           Clear_b,
  input  logic           en,
  input  logic [2:0]     mode,
  input  logic [AW-1:0]  amt,
  input  logic [W-1:0]   I_par,
  input  logic           MSB_in,
  input  logic           LSB_in,
  input  logic           start,
  output logic [W-1:0]   A_par,
  output logic           ser_out,
  output logic           busy,
  output logic           done
);

  localparam logic [AW:0] CNT_INIT = (AW+1)'(W - 1);

  state_t       state;
  logic [AW:0]  bit_cnt;
  logic [W-1:0] a_manual;

  usr_next_value #(
    .W  (W),
    .AW (AW)
  ) u_next (
    .mode   (mode_t'(mode)),
    .a      (A_par),
    .i_par  (I_par),
    .msb_in (MSB_in),
    .lsb_in (LSB_in),
    .amt    (amt),
    .a_next (a_manual)
  );

  assign ser_out = A_par[0];

  always_ff @(posedge CLK) begin
    if (!Clear_b) begin
      A_par   <= '0;
      state   <= IDLE;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!en) begin
      // Everything freezes; done is forced low so a stalled pulse is not stretched.
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            A_par   <= I_par;
            bit_cnt <= CNT_INIT;
            state   <= SHIFT;
            busy    <= 1'b1;
          end else begin
            A_par <= a_manual;
          end
        end
        SHIFT: begin
          // The final shift happens on the same edge that leaves SHIFT, so the
          // register ends up fully refilled with MSB_in.
          A_par <= {MSB_in, A_par[W-1:1]};
          if (bit_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_register_n.sv
// tb/tb_universal_shift_register_n.sv - directed self-checking bench for universal_shift_register_n
module tb_universal_shift_register_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear_b, en;
  logic [2:0] mode4, mode8;
  logic [1:0] amt4;
  logic [2:0] amt8;
  logic [3:0] i_par4;
  logic [7:0] i_par8;
  logic       msb4, lsb4, start4, msb8, lsb8, start8;
  logic [3:0] a4;
  logic [7:0] a8;
  logic       ser4, busy4, done4, ser8, busy8, done8;

  int errors = 0;
  int checks = 0;

  logic [3:0] pat4;
  logic [7:0] pat8;

  universal_shift_register_n #(.W(4)) dut4 (
    .CLK(clk), .Clear_b(clear_b), .en(en), .mode(mode4), .amt(amt4),
    .I_par(i_par4), .MSB_in(msb4), .LSB_in(lsb4), .start(start4),
    .A_par(a4), .ser_out(ser4), .busy(busy4), .done(done4)
  );

  universal_shift_register_n #(.W(8)) dut8 (
    .CLK(clk), .Clear_b(clear_b), .en(en), .mode(mode8), .amt(amt8),
    .I_par(i_par8), .MSB_in(msb8), .LSB_in(lsb8), .start(start8),
    .A_par(a8), .ser_out(ser8), .busy(busy8), .done(done8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear_b = 1'b0; en = 1'b1;
    mode4 = 3'b000; amt4 = '0; i_par4 = '0; msb4 = 0; lsb4 = 0; start4 = 0;
    mode8 = 3'b000; amt8 = '0; i_par8 = '0; msb8 = 0; lsb8 = 0; start8 = 0;

    // Reset state
    tick();
    chk("rst_a", a4, 4'b0000);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_a8", a8, 8'h00);

    // Reset while busy aborts
    clear_b = 1'b1; i_par4 = 4'b1010; start4 = 1;
    tick();
    chk("pre_rst_a", a4, 4'b1010);
    chk("pre_rst_busy", busy4, 1'b1);
    start4 = 0; clear_b = 1'b0;
    tick();
    chk("rst_busy_a", a4, 4'b0000);
    chk("rst_busy_busy", busy4, 1'b0);
    chk("rst_busy_done", done4, 1'b0);

    // Reset with en=0 still clears
    clear_b = 1'b1; mode4 = 3'b011; i_par4 = 4'b1111;
    tick();
    chk("load_f", a4, 4'b1111);
    en = 1'b0; clear_b = 1'b0;
    tick();
    chk("rst_en0", a4, 4'b0000);
    clear_b = 1'b1; en = 1'b1;

    // Manual modes
    mode4 = 3'b011; i_par4 = 4'b1010; tick(); chk("load", a4, 4'b1010);
    mode4 = 3'b001; msb4 = 1;         tick(); chk("shr", a4, 4'b1101);
    mode4 = 3'b010; lsb4 = 0;         tick(); chk("shl", a4, 4'b1010);
    mode4 = 3'b100;                   tick(); chk("ror", a4, 4'b0101);
    mode4 = 3'b101;                   tick(); chk("rol", a4, 4'b1010);
    mode4 = 3'b000;                   tick(); chk("hold1", a4, 4'b1010);
                                      tick(); chk("hold2", a4, 4'b1010);

    mode4 = 3'b011; i_par4 = 4'b1000; tick(); chk("load8", a4, 4'b1000);
    mode4 = 3'b110;                   tick(); chk("asr", a4, 4'b1100);
    mode4 = 3'b011; i_par4 = 4'b1011; tick(); chk("loadb", a4, 4'b1011);
    mode4 = 3'b111; amt4 = 2'd2;      tick(); chk("shrn2", a4, 4'b0010);
    amt4 = 2'd0;                      tick(); chk("shrn0", a4, 4'b0010);

    // en=0 holds in manual mode
    en = 1'b0; mode4 = 3'b011; i_par4 = 4'b0000;
    tick(); chk("en0_hold", a4, 4'b0010);
    en = 1'b1; mode4 = 3'b000;

    // Serialise 1011, MSB_in=1, with start and LOAD interference while busy
    pat4 = 4'b1011; i_par4 = pat4; msb4 = 1; start4 = 1;
    tick();
    chk("ser_b0", ser4, pat4[0]);
    chk("ser_busy0", busy4, 1'b1);
    start4 = 0;
    for (int k = 1; k < 4; k++) begin
      if (k == 1) begin start4 = 1; i_par4 = 4'b0000; end
      if (k == 2) begin mode4 = 3'b011; i_par4 = 4'b0000; end
      tick();
      start4 = 0; mode4 = 3'b000;
      chk($sformatf("ser_b%0d", k), ser4, pat4[k]);
      chk($sformatf("ser_busy%0d", k), busy4, 1'b1);
      chk($sformatf("ser_nodone%0d", k), done4, 1'b0);
    end
    tick();
    chk("ser_done", done4, 1'b1);
    chk("ser_busy_fall", busy4, 1'b0);
    chk("ser_a_fill", a4, 4'b1111);
    tick();
    chk("ser_done_fall", done4, 1'b0);
    chk("ser_idle_a", a4, 4'b1111);

    // Stall for 3 cycles after the second bit
    i_par4 = pat4; start4 = 1;
    tick(); start4 = 0; chk("stall_b0", ser4, pat4[0]);
    tick();             chk("stall_b1", ser4, pat4[1]);
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("stall_ser%0d", s), ser4, pat4[1]);
      chk($sformatf("stall_busy%0d", s), busy4, 1'b1);
      chk($sformatf("stall_done%0d", s), done4, 1'b0);
    end
    en = 1'b1;
    tick(); chk("stall_b2", ser4, pat4[2]);
    tick(); chk("stall_b3", ser4, pat4[3]); chk("stall_nodone", done4, 1'b0);
    tick(); chk("stall_done", done4, 1'b1); chk("stall_busy_fall", busy4, 1'b0);
    tick(); chk("stall_done_fall", done4, 1'b0);

    // Abort at the third bit
    i_par4 = pat4; start4 = 1;
    tick(); start4 = 0;
    tick();
    tick(); chk("abort_b2", ser4, pat4[2]);
    clear_b = 1'b0;
    tick();
    chk("abort_a", a4, 4'b0000);
    chk("abort_busy", busy4, 1'b0);
    clear_b = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("abort_nodone%0d", s), done4, 1'b0);
    end

    // W=8 back-to-back: first 0xFF, then 0x5A started in the done cycle
    i_par8 = 8'hFF; msb8 = 0; start8 = 1;
    tick(); start8 = 0;
    chk("b2b_first_busy", busy8, 1'b1);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("b2b_first_nodone%0d", k), done8, 1'b0);
    end
    tick();
    chk("b2b_first_done", done8, 1'b1);
    pat8 = 8'h5A; i_par8 = pat8; start8 = 1;
    tick(); start8 = 0;
    chk("b2b_busy0", busy8, 1'b1);
    chk("b2b_done_fall", done8, 1'b0);
    chk("b2b_b0", ser8, pat8[0]);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("b2b_b%0d", k), ser8, pat8[k]);
      chk($sformatf("b2b_nodone%0d", k), done8, 1'b0);
    end
    tick();
    chk("b2b_done", done8, 1'b1);
    chk("b2b_busy_fall", busy8, 1'b0);
    chk("b2b_a_fill", a8, 8'h00);
    tick();
    chk("b2b_done_end", done8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register_n.md
# universal_shift_register_n

Parametrised W-bit universal shift register with eight operating modes and a built-in auto-serialise engine. It replaces the fixed 4-bit four-mode register. The block serves as a parallel-to-serial converter, rotator and scaler in the register/counter datapath. The serialise engine loads a parallel word and shifts it out LSB-first under a small FSM, with busy/done status.

## Interface
Parameters:
- W, 4, register width in bits (W ≥ 2).
- AW, $clog2(W), width of the shift-amount input (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock.
- Clear_b  input  1  synchronous active-low reset, sampled on CLK rising edge.
- en  input  1  clock enable for all state (register, FSM, counter, done).
- mode  input  3  operation select (see Operation).
- amt  input  AW  shift distance for mode 111.
- I_par  input  W  parallel load data.
- MSB_in  input  1  serial fill bit entering at bit W-1 on right shifts.
- LSB_in  input  1  serial fill bit entering at bit 0 on left shifts.
- start  input  1  request auto-serialise of I_par.
- A_par  output  W  register contents.
- ser_out  output  1  always A_par[0].
- busy  output  1  high while the serialise FSM is in SHIFT.
- done  output  1  one-cycle pulse after the last serial bit.

## Operation
- Reset (Clear_b=0 at edge, regardless of en) sets the following: A_par=0, FSM=IDLE, bit counter=0, busy=0, done=0. Reset mid-serialise aborts the transfer and no done is produced.
- en=0: all state holds, including the FSM and the counter. done is held low. The transfer resumes exactly where it stopped.
- Manual modes apply only in IDLE with start=0:
  - 000 hold.
  - 001 shift right: A <= {MSB_in, A[W-1:1]}.
  - 010 shift left: A <= {A[W-2:0], LSB_in}.
  - 011 parallel load: A <= I_par.
  - 100 rotate right: A <= {A[0], A[W-1:1]}.
  - 101 rotate left: A <= {A[W-2:0], A[W-1]}.
  - 110 arithmetic shift right: A <= {A[W-1], A[W-1:1]}.
  - 111 logical shift right by amt, zero fill. amt=0 holds. amt ≥ W gives all zeros (possible only for non-power-of-2 W).
- Serialise FSM, states IDLE and SHIFT:
  - IDLE with start=1 (en=1): A <= I_par, counter <= W-1, go to SHIFT. start has priority over mode.
  - SHIFT: each enabled cycle A <= {MSB_in, A[W-1:1]} and the counter decrements. On the edge where counter==0, go to IDLE and register done=1 for exactly one cycle.
  - In SHIFT, mode, amt and start are ignored. start during busy is dropped, not queued.
  - start may be reasserted in the cycle done is high; a new load then occurs on that edge (back-to-back transfers).

## Timing
- All outputs are registered, except ser_out, which is a direct wire from A_par[0].
- Manual modes have one-cycle latency: the result is visible after the edge on which mode is sampled.
- Serialise sequence, with edge 0 as the start edge:
  - busy rises after edge 0.
  - ser_out presents I_par[0] after edge 0 and I_par[k] after edge k, for k=0..W-1.
  - busy falls and done rises after edge W.
  - done falls after edge W+1.
- Total from start edge to done: W+1 cycles with en continuously high. Each en=0 cycle adds one cycle.
- After the transfer completes, A_par holds W copies of MSB_in shifted in, assuming MSB_in is held constant.

## Structure
- Package shift_reg_pkg:
  - typedef enum logic [2:0] mode_t, values HOLD, SHR, SHL, LOAD, ROR, ROL, ASR, SHRN.
  - typedef enum logic state_t, values IDLE, SHIFT.
- One combinational sub-module, usr_next_value, computes next A from (mode, A, I_par, MSB_in, LSB_in, amt). It contains all eight mode cases, including the variable shift.
- The top level contains the FSM, the counter (AW+1 bits, sized for W-1), the register, the enable and reset logic, and the done register.

## Test plan
- Reset: Clear_b=0 for one edge while A_par=1010 and busy=1 → A_par=0000, busy=0, done=0. Holding Clear_b=0 with en=0 still clears.
- Manual modes, W=4:
  - load 1010.
  - SHR with MSB_in=1 → 1101.
  - SHL with LSB_in=0 → 1010.
  - ROR → 0101.
  - ROL → 1010.
  - hold two cycles → 1010.
- Arithmetic and variable shift:
  - load 1000, ASR → 1100.
  - load 1011, SHRN amt=2 → 0010.
  - SHRN amt=0 → unchanged.
- Serialise, I_par=1011, MSB_in=1:
  - ser_out reads 1,1,0,1 over four busy cycles.
  - done pulses one cycle, then A_par=1111.
  - a start pulse during busy is ignored.
  - mode=LOAD during busy does not disturb the transfer.
- Stall and abort:
  - en=0 for 3 cycles after the second bit → ser_out and busy frozen; done arrives 3 cycles late with the correct bit order.
  - separate run: Clear_b=0 at the third bit → A=0, busy=0, no done.
- Back-to-back, with W=8 also run:
  - start reasserted during the done cycle with I_par=0x5A → second transfer begins immediately.
  - bits 0,1,0,1,1,0,1,0 emitted.
  - done after 9 cycles.
